// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Frame-latched 4-digit common-anode 7-segment scanner with blink.
// Option   : SEG_LEADING_ZERO_BLANK_EN blanks the minutes-tens slot when zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver #(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLINK_CYCLES = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] min_tens,
   input  logic [3:0] min_ones,
   input  logic [3:0] sec_tens,
   input  logic [3:0] sec_ones,
   input  logic       sel,
   input  logic       adj,
   output logic [6:0] seg,
   output logic [3:0] an
);

   localparam int DCNT_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int BCNT_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [DCNT_W-1:0] C_DCNT_LAST = DCNT_W'(DIGIT_CYCLES - 1);
   localparam logic [BCNT_W-1:0] C_BCNT_LAST = BCNT_W'(BLINK_CYCLES - 1);

   logic [DCNT_W-1:0] r_dcnt;
   logic [1:0]        r_idx;
   logic [3:0]        r_shadow [4];
   logic [BCNT_W-1:0] r_bcnt;
   logic              r_blink_on;

   logic              w_tick;
   logic [3:0]        w_digit;
   logic [6:0]        w_dec;
   logic              w_blank;

   assign w_tick  = (r_dcnt == C_DCNT_LAST);
   assign w_digit = r_shadow[r_idx];

   always_comb begin
      w_dec = 7'h3F;
      case (w_digit)
         4'd0:    w_dec = 7'h40;
         4'd1:    w_dec = 7'h79;
         4'd2:    w_dec = 7'h24;
         4'd3:    w_dec = 7'h30;
         4'd4:    w_dec = 7'h19;
         4'd5:    w_dec = 7'h12;
         4'd6:    w_dec = 7'h02;
         4'd7:    w_dec = 7'h78;
         4'd8:    w_dec = 7'h00;
         4'd9:    w_dec = 7'h10;
         default: w_dec = 7'h3F;
      endcase
   end

   // Selected field: minutes occupy idx 2,3 (sel=0), seconds idx 0,1 (sel=1).
   always_comb begin
      w_blank = adj && !r_blink_on && (sel ? !r_idx[1] : r_idx[1]);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if ((r_idx == 2'd3) && (r_shadow[3] == 4'd0)) begin
         w_blank = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dcnt     <= '0;
         r_idx      <= 2'd0;
         r_shadow   <= '{default: 4'd0};
         r_bcnt     <= '0;
         r_blink_on <= 1'b1;
         seg        <= 7'h7F;
         an         <= 4'hF;
      end else begin
         if (w_tick) begin
            r_dcnt <= '0;
            r_idx  <= r_idx + 2'd1;
            // Latch a whole frame at once so a scan never mixes two values.
            if (r_idx == 2'd3) begin
               r_shadow[0] <= sec_ones;
               r_shadow[1] <= sec_tens;
               r_shadow[2] <= min_ones;
               r_shadow[3] <= min_tens;
            end
         end else begin
            r_dcnt <= r_dcnt + 1'b1;
         end

         if (!adj) begin
            r_bcnt     <= '0;
            r_blink_on <= 1'b1;
         end else if (r_bcnt == C_BCNT_LAST) begin
            r_bcnt     <= '0;
            r_blink_on <= !r_blink_on;
         end else begin
            r_bcnt <= r_bcnt + 1'b1;
         end

         if (w_blank) begin
            seg <= 7'h7F;
            an  <= 4'hF;
         end else begin
            seg <= w_dec;
            an  <= ~(4'b0001 << r_idx);
         end
      end
   end

endmodule

`default_nettype wire
